// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the bundle pipeline register:
//   state_e        - storage state; the encoding equals the stored bundle count
//   MAX_LANES      - widest bundle supported by the helper function
//   lane_mask_from - mask of every bit at or above the lowest set bit of sel
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned MAX_LANES = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Lanes from the lowest requested lane upward (the lane itself and all
    // younger lanes); zero when sel is zero.
    function automatic logic [MAX_LANES-1:0] lane_mask_from(input logic [MAX_LANES-1:0] sel);
        logic                 seen;
        logic [MAX_LANES-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            seen = seen | sel[i];
            m[i] = seen;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_lane_slot.sv
// ----------------------------------------------------------------------------
// pipe_lane_slot
// One lane of one storage entry: a valid bit plus a W-bit payload.
//   clk_i    clock
//   rst_i    synchronous active-high reset (acts as clear)
//   load_i   capture valid_i/data_i
//   clear_i  drop the lane; payload zeroed when CLEAR_DATA=1 (wins over load_i)
//   valid_i  incoming lane valid
//   data_i   incoming lane payload
//   valid_o  stored lane valid
//   data_o   stored lane payload
// ----------------------------------------------------------------------------
module pipe_lane_slot #(
    parameter int unsigned W          = 32,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (rst_i || clear_i) begin
            valid_d = 1'b0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        valid_q <= valid_d;
        data_q  <= data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_bundle_reg.sv
// ----------------------------------------------------------------------------
// pipe_bundle_reg
// Two-entry (head + skid) pipeline register for multi-lane issue bundles with
// whole-pipe and partial (lane-range) flush.
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   per-lane valid of the upstream bundle (lane 0 oldest)
//   in_data    per-lane payload, lane k at [k*W +: W]
//   in_ready   high when a bundle can be accepted (state-register driven)
//   out_valid  per-lane valid of the head bundle
//   out_data   head bundle payload
//   out_ready  downstream consumes the head bundle
//   flush_all  drop all stored bundles and the same-cycle input
//   flush_from kill head lanes from the lowest set bit upward
//   occupancy  stored bundle count 0..2
// ----------------------------------------------------------------------------
module pipe_bundle_reg #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned W          = 32,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   in_valid,
    input  logic [LANES*W-1:0] in_data,
    output logic               in_ready,
    output logic [LANES-1:0]   out_valid,
    output logic [LANES*W-1:0] out_data,
    input  logic               out_ready,
    input  logic               flush_all,
    input  logic [LANES-1:0]   flush_from,
    output logic [1:0]         occupancy
);

    import pipe_pkg::*;

    state_e state_q, state_d;

    logic [LANES-1:0]   head_v, skid_v;
    logic [LANES*W-1:0] head_dat, skid_dat;
    logic [LANES-1:0]   head_in_v;
    logic [LANES*W-1:0] head_in_d;

    logic [LANES-1:0] head_load, head_clr;
    logic             head_src_skid;
    logic             skid_load, skid_clr;

    logic             in_fire, out_fire, flush_eff;
    logic [MAX_LANES-1:0] flush_ext, kill_full;
    logic [LANES-1:0] kill, head_keep;
    logic             unused_kill_hi;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = head_v;
    assign out_data  = head_dat;
    assign occupancy = state_q;

    assign in_fire  = (|in_valid) & in_ready;
    assign out_fire = (|head_v) & out_ready;

    always_comb begin
        flush_ext             = '0;
        flush_ext[LANES-1:0]  = flush_from;
        kill_full             = lane_mask_from(flush_ext);
    end
    assign kill           = kill_full[LANES-1:0];
    assign unused_kill_hi = ^kill_full;
    assign head_keep      = head_v & ~kill;

    // A partial flush only targets a head that is still held: once the head
    // fires out this cycle there is nothing left to kill.
    assign flush_eff = (|flush_from) & ~out_fire & (state_q != ST_EMPTY);

    assign head_in_v = head_src_skid ? skid_v   : in_valid;
    assign head_in_d = head_src_skid ? skid_dat : in_data;

    always_comb begin
        state_d       = state_q;
        head_load     = '0;
        head_clr      = '0;
        head_src_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush_all) begin
            state_d  = ST_EMPTY;
            head_clr = '1;
            skid_clr = 1'b1;
        end else if (flush_eff) begin
            if (|head_keep) begin
                // Head survives with fewer lanes; an accepted input (only
                // possible from ONE) still has to be stored behind it.
                head_clr = kill;
                if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end
            end else if (state_q == ST_TWO) begin
                head_load     = '1;
                head_src_skid = 1'b1;
                skid_clr      = 1'b1;
                state_d       = ST_ONE;
            end else if (in_fire) begin
                head_load = '1;
                state_d   = ST_ONE;
            end else begin
                head_clr = '1;
                state_d  = ST_EMPTY;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_load = '1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = '1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (out_fire) begin
                        head_clr = '1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        head_load     = '1;
                        head_src_skid = 1'b1;
                        skid_clr      = 1'b1;
                        state_d       = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_lane_slot #(
            .W          (W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_head (
            .clk_i   (clk),
            .rst_i   (rst),
            .load_i  (head_load[k]),
            .clear_i (head_clr[k]),
            .valid_i (head_in_v[k]),
            .data_i  (head_in_d[k*W +: W]),
            .valid_o (head_v[k]),
            .data_o  (head_dat[k*W +: W])
        );

        pipe_lane_slot #(
            .W          (W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_skid (
            .clk_i   (clk),
            .rst_i   (rst),
            .load_i  (skid_load),
            .clear_i (skid_clr),
            .valid_i (in_valid[k]),
            .data_i  (in_data[k*W +: W]),
            .valid_o (skid_v[k]),
            .data_o  (skid_dat[k*W +: W])
        );
    end

endmodule

// File: tb/tb_pipe_bundle_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_bundle_reg
// Directed scenarios followed by random traffic, every cycle compared against
// a queue-of-bundles reference model.
// ----------------------------------------------------------------------------
module tb_pipe_bundle_reg;

    localparam int LANES = 2;
    localparam int W     = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [LANES-1:0]   in_valid;
    logic [LANES*W-1:0] in_data;
    logic               in_ready;
    logic [LANES-1:0]   out_valid;
    logic [LANES*W-1:0] out_data;
    logic               out_ready;
    logic               flush_all;
    logic [LANES-1:0]   flush_from;
    logic [1:0]         occupancy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        logic [LANES-1:0]   v;
        logic [LANES*W-1:0] d;
    } bundle_t;

    bundle_t mq[$];

    pipe_bundle_reg #(
        .LANES      (LANES),
        .W          (W),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_all  (flush_all),
        .flush_from (flush_from),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [31:0] l1, input logic [31:0] l0);
        return {l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, "_occ"}, 64'(occupancy), 64'(n));
        chk({tag, "_rdy"}, 64'(in_ready), 64'(n < 2));
        chk({tag, "_vld"}, 64'(out_valid), (n > 0) ? 64'(mq[0].v) : 64'd0);
        for (int k = 0; k < LANES; k++) begin
            if (n > 0 && mq[0].v[k]) begin
                chk({tag, "_dat"}, 64'(out_data[k*W +: W]), 64'(mq[0].d[k*W +: W]));
            end
        end
    endtask

    // Drive one cycle, advance the reference model with the pre-edge view,
    // then compare after the edge.
    task automatic cycle(input logic r, input logic fa, input logic [LANES-1:0] ff,
                         input logic [LANES-1:0] iv, input logic [LANES*W-1:0] id,
                         input logic ordy, input string tag);
        bundle_t h;
        bundle_t nb;
        logic    infire, outfire, kl;
        rst        = r;
        flush_all  = fa;
        flush_from = ff;
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        infire  = (|iv) && (mq.size() < 2);
        outfire = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (r || fa) begin
            mq.delete();
        end else begin
            if ((|ff) && !outfire && mq.size() > 0) begin
                h  = mq[0];
                kl = 1'b0;
                for (int k = 0; k < LANES; k++) begin
                    kl = kl | ff[k];
                    if (kl) begin
                        h.v[k]         = 1'b0;
                        h.d[k*W +: W]  = '0;
                    end
                end
                if (h.v == '0) void'(mq.pop_front());
                else mq[0] = h;
            end else if (outfire) begin
                void'(mq.pop_front());
            end
            if (infire) begin
                nb.v = iv;
                nb.d = id;
                mq.push_back(nb);
            end
        end
        check_model(tag);
    endtask

    task automatic go(input logic [LANES-1:0] iv, input logic [LANES*W-1:0] id,
                      input logic ordy, input string tag);
        cycle(1'b0, 1'b0, '0, iv, id, ordy, tag);
    endtask

    initial begin
        logic               r_r, r_fa, r_or;
        logic [LANES-1:0]   r_ff, r_iv;
        logic [LANES*W-1:0] r_id;

        rst = 1'b1; flush_all = 1'b0; flush_from = '0;
        in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, "rst0");
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, "rst1");
        chk("rst_data", out_data, 64'd0);

        // One-cycle latency, occupancy stays 1 while streaming
        go(2'b11, pk(32'hB, 32'hA), 1'b1, "s37a");
        chk("s37_data", out_data, pk(32'hB, 32'hA));
        chk("s37_vld", 64'(out_valid), 64'd3);
        go(2'b11, pk(32'hD, 32'hC), 1'b1, "s37b");
        chk("s37_occ", 64'(occupancy), 64'd1);
        chk("s37_data2", out_data, pk(32'hD, 32'hC));
        go(2'b00, '0, 1'b1, "s37c");

        // Stall fills the skid; third bundle is held upstream
        go(2'b11, pk(32'h0, 32'h1), 1'b0, "s38a");
        go(2'b11, pk(32'h0, 32'h2), 1'b0, "s38b");
        chk("s38_occ", 64'(occupancy), 64'd2);
        chk("s38_rdy", 64'(in_ready), 64'd0);
        go(2'b11, pk(32'h0, 32'h3), 1'b0, "s38c");
        chk("s38_head1", out_data, pk(32'h0, 32'h1));
        go(2'b11, pk(32'h0, 32'h3), 1'b1, "s38d");
        chk("s38_head2", out_data, pk(32'h0, 32'h2));
        go(2'b11, pk(32'h0, 32'h3), 1'b1, "s38e");
        chk("s38_head3", out_data, pk(32'h0, 32'h3));
        go(2'b00, '0, 1'b1, "s38f");
        chk("s38_empty", 64'(occupancy), 64'd0);

        // Partial flush leaves skid intact, then head removal promotes skid
        go(2'b11, pk(32'h11, 32'h10), 1'b0, "s39a");
        go(2'b11, pk(32'h21, 32'h20), 1'b0, "s39b");
        cycle(1'b0, 1'b0, 2'b10, '0, '0, 1'b0, "s39c");
        chk("s39_vld", 64'(out_valid), 64'd1);
        chk("s39_data", out_data, pk(32'h0, 32'h10));
        chk("s39_occ", 64'(occupancy), 64'd2);
        cycle(1'b0, 1'b0, 2'b01, '0, '0, 1'b0, "s39d");
        chk("s39_promo", out_data, pk(32'h21, 32'h20));
        chk("s39_occ1", 64'(occupancy), 64'd1);
        go(2'b00, '0, 1'b1, "s39e");

        // flush_all drops the same-cycle input
        go(2'b11, pk(32'h41, 32'h40), 1'b0, "s40a");
        cycle(1'b0, 1'b1, '0, 2'b11, pk(32'h51, 32'h50), 1'b0, "s40b");
        chk("s40_vld", 64'(out_valid), 64'd0);
        chk("s40_data", out_data, 64'd0);

        // flush_from together with out_fire is ignored
        go(2'b11, pk(32'h61, 32'h60), 1'b0, "s41a");
        go(2'b11, pk(32'h71, 32'h70), 1'b0, "s41b");
        chk("s41_head", out_data, pk(32'h61, 32'h60));
        cycle(1'b0, 1'b0, 2'b01, '0, '0, 1'b1, "s41c");
        chk("s41_next", out_data, pk(32'h71, 32'h70));
        chk("s41_vld", 64'(out_valid), 64'd3);
        go(2'b00, '0, 1'b1, "s41d");

        // Reset in TWO with input presented
        go(2'b11, pk(32'h81, 32'h80), 1'b0, "s42a");
        go(2'b01, pk(32'h91, 32'h90), 1'b0, "s42b");
        cycle(1'b1, 1'b0, '0, 2'b11, pk(32'hA1, 32'hA0), 1'b1, "s42c");
        chk("s42_occ", 64'(occupancy), 64'd0);
        chk("s42_rdy", 64'(in_ready), 64'd1);
        chk("s42_vld", 64'(out_valid), 64'd0);
        chk("s42_data", out_data, 64'd0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r_r  = ($urandom_range(0, 49) == 0);
            r_fa = ($urandom_range(0, 19) == 0);
            r_ff = ($urandom_range(0, 4) == 0) ? LANES'($urandom_range(1, 3)) : '0;
            r_iv = LANES'($urandom_range(0, 3));
            r_id = {$urandom, $urandom};
            r_or = ($urandom_range(0, 2) != 0);
            cycle(r_r, r_fa, r_ff, r_iv, r_id, r_or, "rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
